reg_file_alu_pipe: RTL

REG_FILE_ALU_PIPE -- requirements
Module: reg_file_alu_pipe

---
 rtl/reg_file_alu_pkg.sv | 26 ++
 rtl/reg_file_alu_pipe_alu_flags.sv | 53 +++++
 rtl/reg_file_alu_pipe.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/reg_file_alu_pkg.sv
// Shared types for the register-file / ALU pipeline.
//   alu_op_e    : 3-bit ALU opcode as carried in the ALUControl port
//   alu_flags_t : Zero / Carry / Negative / Overflow result flags
package reg_file_alu_pkg;

  localparam int ALU_OP_W = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SHL = 3'b101,
    ALU_SHR = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic negative;
    logic overflow;
  } alu_flags_t;

endpackage

// File: rtl/reg_file_alu_pipe_alu_flags.sv
// Combinational ALU producing a DATA_W result and four flags.
//   a, b   : operands
//   op     : opcode
//   result : op(a, b), truncated to DATA_W
//   flags  : zero/negative for every op; carry/overflow only for add and sub
module alu_flags
  import reg_file_alu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_e           op,
  output logic [DATA_W-1:0] result,
  output alu_flags_t        flags
);

  localparam int SHW = $clog2(DATA_W);
  localparam int MSB = DATA_W - 1;

  logic [DATA_W:0] sum_w;
  logic [DATA_W:0] diff_w;

  always_comb begin
    result = '0;
    flags  = '0;
    sum_w  = {1'b0, a} + {1'b0, b};
    diff_w = {1'b0, a} - {1'b0, b};
    case (op)
      ALU_ADD: begin
        result         = sum_w[MSB:0];
        flags.carry    = sum_w[DATA_W];
        flags.overflow = (a[MSB] == b[MSB]) && (sum_w[MSB] != a[MSB]);
      end
      ALU_SUB: begin
        result         = diff_w[MSB:0];
        // borrow bit clear means a >= b unsigned
        flags.carry    = ~diff_w[DATA_W];
        flags.overflow = (a[MSB] != b[MSB]) && (diff_w[MSB] != a[MSB]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SHL: result = a << b[SHW-1:0];
      ALU_SHR: result = a >> b[SHW-1:0];
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
    flags.zero     = (result == '0);
    flags.negative = result[MSB];
  end

endmodule

// File: rtl/reg_file_alu_pipe.sv
// Two-stage register-file + ALU pipeline with valid/ready handshakes.
//   CLK, reset          : clock, synchronous active-high reset
//   in_valid/in_ready   : instruction handshake (RA1, RA2, WA, immediate,
//                         ALUControl, ALUSrc, write_enable)
//   res_valid/res_ready : result handshake (ALUResult + flags)
//   cpu_out             : registered copy of reg[OUT_REG]
// S1 holds operands; the ALU evaluates S1 combinationally, writes the
// register file when S1 advances, and S2 registers result and flags.
module reg_file_alu_pipe
  import reg_file_alu_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int OUT_REG = 2**ADDR_W - 1
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  input  logic [ADDR_W-1:0] WA,
  input  logic [DATA_W-1:0] immediate,
  input  logic [2:0]        ALUControl,
  input  logic              ALUSrc,
  input  logic              write_enable,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] ALUResult,
  output logic              Zero,
  output logic              Carry,
  output logic              Negative,
  output logic              Overflow,
  output logic [DATA_W-1:0] cpu_out
);

  localparam int                NREG    = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] OUT_IDX = ADDR_W'(OUT_REG);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  alu_op_e           s1_op_q, s1_op_d;
  logic [ADDR_W-1:0] s1_wa_q, s1_wa_d;
  logic              s1_we_q, s1_we_d;

  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] result_q, result_d;
  alu_flags_t        flags_q, flags_d;
  logic [DATA_W-1:0] cpu_out_q, cpu_out_d;

  logic [DATA_W-1:0] alu_result;
  alu_flags_t        alu_fl;
  logic              s1_advance, accept, bp_a, bp_b;

  alu_flags #(.DATA_W(DATA_W)) u_alu (
    .a      (s1_a_q),
    .b      (s1_b_q),
    .op     (s1_op_q),
    .result (alu_result),
    .flags  (alu_fl)
  );

  always_comb begin
    s1_advance = s1_valid_q && (!res_valid_q || res_ready);
    in_ready   = reset || !s1_valid_q || s1_advance;
    accept     = in_valid && in_ready && !reset;
    // S1 result forwarded whether or not S1 moves this edge
    bp_a = s1_valid_q && s1_we_q && (s1_wa_q == RA1);
    bp_b = s1_valid_q && s1_we_q && (s1_wa_q == RA2) && !ALUSrc;

    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s1_wa_d    = s1_wa_q;
    s1_we_d    = s1_we_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_a_d     = bp_a ? alu_result : regs_q[RA1];
      s1_b_d     = ALUSrc ? immediate : (bp_b ? alu_result : regs_q[RA2]);
      s1_op_d    = alu_op_e'(ALUControl);
      s1_wa_d    = WA;
      s1_we_d    = write_enable;
    end else if (s1_advance) begin
      s1_valid_d = 1'b0;
    end

    res_valid_d = res_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    if (s1_advance) begin
      res_valid_d = 1'b1;
      result_d    = alu_result;
      flags_d     = alu_fl;
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end

    regs_d = regs_q;
    if (s1_advance && s1_we_q) regs_d[s1_wa_q] = alu_result;

    cpu_out_d = regs_q[OUT_IDX];
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_op_q     <= ALU_ADD;
      s1_wa_q     <= '0;
      s1_we_q     <= 1'b0;
      res_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      regs_q      <= '{default: '0};
      cpu_out_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_op_q     <= s1_op_d;
      s1_wa_q     <= s1_wa_d;
      s1_we_q     <= s1_we_d;
      res_valid_q <= res_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      regs_q      <= regs_d;
      cpu_out_q   <= cpu_out_d;
    end
  end

  assign res_valid = res_valid_q;
  assign ALUResult = result_q;
  assign Zero      = flags_q.zero;
  assign Carry     = flags_q.carry;
  assign Negative  = flags_q.negative;
  assign Overflow  = flags_q.overflow;
  assign cpu_out   = cpu_out_q;

endmodule
